// File: rtl/div_scheduler.sv
// Two-requester round-robin front end for a single repeated-subtraction divider.
// One operation in flight; response is registered and tagged with the requester id.
module div_scheduler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_q,
  output logic [W-1:0] rsp_r,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         id_q, id_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         last_grant_q, last_grant_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_q_q, rsp_q_d;
  logic [W-1:0] rsp_r_q, rsp_r_d;
  logic         rsp_err_q, rsp_err_d;

  logic         grant_s;
  logic         req0_ready_s;
  logic         req1_ready_s;

  // Arbitration, handshake qualification and divider next-state logic
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_q_d      = rsp_q_q;
    rsp_r_d      = rsp_r_q;
    rsp_err_d    = rsp_err_q;

    // A lone requester always wins; on a tie the one not served last wins.
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    req0_ready_s = (state_q == IDLE) && (grant_s == 1'b0) && req0_valid;
    req1_ready_s = (state_q == IDLE) && (grant_s == 1'b1) && req1_valid;

    case (state_q)
      IDLE: begin
        if (req0_ready_s) begin
          a_d          = req0_a;
          b_d          = req0_b;
          id_d         = 1'b0;
          rem_d        = req0_a;
          cnt_d        = '0;
          last_grant_d = 1'b0;
          state_d      = CALC;
        end else if (req1_ready_s) begin
          a_d          = req1_a;
          b_d          = req1_b;
          id_d         = 1'b1;
          rem_d        = req1_a;
          cnt_d        = '0;
          last_grant_d = 1'b1;
          state_d      = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (b_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b1;
          rsp_q_d     = {W{1'b1}};
          rsp_r_d     = a_q;
          state_d     = DONE;
        end else if (rem_q < b_q) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b0;
          rsp_q_d     = cnt_q;
          rsp_r_d     = rem_q;
          state_d     = DONE;
        end else begin
          rem_d   = rem_q - b_q;
          cnt_d   = cnt_q + {{(W-1){1'b0}}, 1'b1};
          state_d = CALC;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rem_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_q_q      <= '0;
      rsp_r_q      <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_q_q      <= rsp_q_d;
      rsp_r_q      <= rsp_r_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_q      = rsp_q_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule
